// File: rtl/unary_pkg.sv
// Shared definitions for the unary adder / sum decoder pair: decoder FSM
// states and the width derivations both sides must agree on.
package unary_pkg;

    // Decoder control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Width of the thermometer sum produced by adding two NOF_BITS operands.
    function automatic int sum_width(input int nof_bits);
        return 2 * nof_bits;
    endfunction

    // Width needed to hold every count 0..sum_width inclusive.
    function automatic int count_width(input int nof_bits);
        return $clog2(2 * nof_bits + 1);
    endfunction

    localparam int NOF_BITS_DEFAULT = 8;
    localparam int SW_DEFAULT       = sum_width(NOF_BITS_DEFAULT);
    localparam int CW_DEFAULT       = count_width(NOF_BITS_DEFAULT);

endpackage

// File: rtl/unary_sum_decoder.sv
// Serial thermometer-to-binary decoder. Captures a thermometer-coded sum,
// walks it LSB first for exactly SW cycles, counts the leading run of ones
// and flags any one found after a zero as a malformed code. The result is
// held on a valid/ready output until taken.
module unary_sum_decoder
    import unary_pkg::*;
#(
    parameter int NOF_BITS = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [2*NOF_BITS-1:0]                 in_sum,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [$clog2(2*NOF_BITS+1)-1:0]       out_count,
    output logic                                  out_err,
    output logic                                  overrun
);

    localparam int SW   = sum_width(NOF_BITS);
    localparam int CW   = count_width(NOF_BITS);
    localparam int IDXW = $clog2(SW);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SW - 1);

    state_e          state_q, state_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;
    logic            zero_seen_q, zero_seen_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            overrun_q, overrun_d;

    // State and datapath registers; reset aborts any scan in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            zero_seen_q <= 1'b0;
            idx_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            err_q       <= err_d;
            zero_seen_q <= zero_seen_d;
            idx_q       <= idx_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic: accept in IDLE, one bit per cycle in SCAN, wait in HOLD.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        count_d     = count_q;
        err_d       = err_q;
        zero_seen_d = zero_seen_q;
        idx_d       = idx_q;
        // Any sum offered while busy is lost; remember that until reset.
        overrun_d   = overrun_q | (in_valid & (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d     = in_sum;
                    count_d     = '0;
                    err_d       = 1'b0;
                    zero_seen_d = 1'b0;
                    idx_d       = '0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                shift_d = shift_q >> 1;
                if (shift_q[0]) begin
                    // A one after a zero breaks the thermometer code; the
                    // count keeps only the leading run.
                    if (zero_seen_q) begin
                        err_d = 1'b1;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end else begin
                    zero_seen_d = 1'b1;
                end
                // Always scan the full width so malformed tails are caught.
                idx_d = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // in_ready is held low for as long as reset is asserted.
    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = (state_q == HOLD);
    assign out_count = count_q;
    assign out_err   = err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_unary_sum_decoder.sv
module tb_unary_sum_decoder;

    localparam int NB = 8;
    localparam int SW = 2 * NB;
    localparam int CW = $clog2(2 * NB + 1);
    localparam int LAT = SW + 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_sum;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_count;
    logic          out_err;
    logic          overrun;

    int total = 0;
    int bad   = 0;

    unary_sum_decoder #(.NOF_BITS(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_err   (out_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] sum;
        int            cnt;
        logic          err;
        int            stall;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference: length of the leading run of ones; well-formed only if the
    // whole word equals 2^count - 1.
    task automatic model(input logic [SW-1:0] s, output int c, output logic e);
        c = 0;
        while (c < SW && s[c]) c++;
        e = (32'(s) != ((32'd1 << c) - 32'd1));
    endtask

    // One full transaction from the "#1 after an edge" phase. stall = number
    // of HOLD cycles with out_ready low before the handshake.
    task automatic run_sum(input logic [SW-1:0] s, input int stall,
                           output int c, output logic e);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_before_accept", int'(in_ready), 1);
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        in_sum    = s;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, LAT);
        c = int'(out_count);
        e = out_err;
        if (stall > 0) begin
            for (int k = 1; k < stall; k++) begin
                @(posedge clk); #1;
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_count", int'(out_count), c);
                chk("hold_err", int'(out_err), int'(e));
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("post_hs_valid", int'(out_valid), 0);
        chk("post_hs_ready", int'(in_ready), 1);
        out_ready = 1'b0;
    endtask

    // Watch for n cycles; returns 1 if out_valid was ever seen.
    task automatic watch_valid(input int n, output int seen);
        seen = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
    endtask

    initial begin
        vec_t        vecs[10];
        int          c, mc, seen, n;
        logic        e, me;
        logic [SW-1:0] s;

        vecs[0] = '{16'h00FF,  8, 1'b0, 0};
        vecs[1] = '{16'h0000,  0, 1'b0, 0};
        vecs[2] = '{16'hFFFF, 16, 1'b0, 0};
        vecs[3] = '{16'h00F7,  3, 1'b1, 0};
        vecs[4] = '{16'h8000,  0, 1'b1, 0};
        vecs[5] = '{16'h003F,  6, 1'b0, 5};
        vecs[6] = '{16'h0001,  1, 1'b0, 0};
        vecs[7] = '{16'h7FFF, 15, 1'b0, 2};
        vecs[8] = '{16'hFFFE,  0, 1'b1, 0};
        vecs[9] = '{16'h0103,  2, 1'b1, 3};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sum = '0;
        #2;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_overrun", int'(overrun), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("release_in_ready", int'(in_ready), 1);

        // Table vectors
        foreach (vecs[i]) begin
            run_sum(vecs[i].sum, vecs[i].stall, c, e);
            $display("vec %0d sum=%h count=%0d err=%0d", i, vecs[i].sum, c, e);
            chk("vec_count", c, vecs[i].cnt);
            chk("vec_err", int'(e), int'(vecs[i].err));
        end

        // Randomized sums against the model
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                n = $urandom_range(0, SW);
                s = SW'((32'd1 << n) - 32'd1);
                if ($urandom_range(0, 3) == 0) s[$urandom_range(0, SW-1)] ^= 1'b1;
            end else begin
                s = SW'($urandom);
            end
            model(s, mc, me);
            run_sum(s, $urandom_range(0, 3), c, e);
            $display("rnd %0d sum=%h count=%0d err=%0d", i, s, c, e);
            chk("rnd_count", c, mc);
            chk("rnd_err", int'(e), int'(me));
        end
        chk("no_overrun_yet", int'(overrun), 0);

        // in_valid pulse during SCAN: dropped, overrun sticky
        out_ready = 1'b1;
        in_valid = 1'b1; in_sum = 16'h000F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        in_valid = 1'b1; in_sum = 16'hFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("scan_overrun_set", int'(overrun), 1);
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("scan_ovr_valid", int'(out_valid), 1);
        chk("scan_ovr_count", int'(out_count), 4);
        chk("scan_ovr_err", int'(out_err), 0);
        watch_valid(SW + 10, seen);
        $display("overrun-in-scan count=4 second_seen=%0d overrun=%0d", seen, overrun);
        chk("scan_ovr_dropped", seen, 0);
        chk("scan_overrun_sticky", int'(overrun), 1);
        out_ready = 1'b0;

        // Reset in the middle of a scan
        in_valid = 1'b1; in_sum = 16'hFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("abort_in_ready", int'(in_ready), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_out_count", int'(out_count), 0);
        chk("abort_out_err", int'(out_err), 0);
        chk("abort_overrun", int'(overrun), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_release_ready", int'(in_ready), 1);
        watch_valid(SW + 5, seen);
        chk("abort_no_result", seen, 0);
        run_sum(16'h0003, 0, c, e);
        $display("after reset sum=0003 count=%0d err=%0d", c, e);
        chk("after_rst_count", c, 2);
        chk("after_rst_err", int'(e), 0);

        // in_valid coinciding with the HOLD handshake
        out_ready = 1'b0;
        in_valid = 1'b1; in_sum = 16'h0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("hs_edge_valid", int'(out_valid), 1);
        chk("hs_edge_in_ready", int'(in_ready), 0);
        out_ready = 1'b1; in_valid = 1'b1; in_sum = 16'hFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("hs_edge_overrun", int'(overrun), 1);
        chk("hs_edge_idle_ready", int'(in_ready), 1);
        watch_valid(SW + 5, seen);
        $display("handshake-edge offer dropped seen=%0d overrun=%0d", seen, overrun);
        chk("hs_edge_dropped", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
